// File: rtl/prbs_checker.sv
// PRBS receive checker: hunts for and locks to a Fibonacci LFSR bit stream, then
// flywheels its own sequence to count bit errors and checked bits while locked.
module prbs_checker #(
  parameter int unsigned       LENGTH      = 16,
  parameter logic [LENGTH-1:0] TAPS        = 16'b0110100000000001,
  parameter int unsigned       LOCK_CNT    = 32,
  parameter int unsigned       WIN         = 1024,
  parameter int unsigned       LOSS_THRESH = 8,
  parameter int unsigned       CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             cnt_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned FILL_W  = $clog2(LENGTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned POS_W   = $clog2(WIN);
  localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [0:LENGTH-1]    r, r_d;
  logic [FILL_W-1:0]    fill_cnt, fill_cnt_d;
  logic [MATCH_W-1:0]   match_cnt, match_cnt_d, match_inc;
  logic [POS_W-1:0]     win_pos, win_pos_d;
  logic [WERR_W-1:0]    win_err, win_err_d, win_err_inc;
  logic                 exp_bit;
  logic                 mismatch;
  logic                 err_evt;
  logic                 bit_evt;

  // State, shift register and sync/window counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      r         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_pos   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_d;
      r         <= r_d;
      fill_cnt  <= fill_cnt_d;
      match_cnt <= match_cnt_d;
      win_pos   <= win_pos_d;
      win_err   <= win_err_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_evt;
    end
  end

  // Next-state and event decode; nothing moves without bit_vld
  always_comb begin
    state_d     = state;
    r_d         = r;
    fill_cnt_d  = fill_cnt;
    match_cnt_d = match_cnt;
    win_pos_d   = win_pos;
    win_err_d   = win_err;
    err_evt     = 1'b0;
    bit_evt     = 1'b0;
    exp_bit     = ^(TAPS & r);
    mismatch    = bit_in ^ exp_bit;
    match_inc   = match_cnt + MATCH_W'(1);
    win_err_inc = win_err + WERR_W'(mismatch);

    if (bit_vld) begin
      case (state)
        HUNT: begin
          r_d = {bit_in, r[0:LENGTH-2]};
          if (fill_cnt == FILL_W'(LENGTH - 1)) begin
            fill_cnt_d  = '0;
            match_cnt_d = '0;
            state_d     = VERIFY;
          end else begin
            fill_cnt_d = fill_cnt + FILL_W'(1);
          end
        end
        VERIFY: begin
          r_d = {bit_in, r[0:LENGTH-2]};
          if (mismatch) begin
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_inc;
            if (match_inc == MATCH_W'(LOCK_CNT)) begin
              state_d = LOCKED;
            end
          end
        end
        LOCKED: begin
          // Flywheel on the regenerated bit so a channel error cannot desync us
          r_d     = {exp_bit, r[0:LENGTH-2]};
          bit_evt = 1'b1;
          err_evt = mismatch;
          if (win_err_inc == WERR_W'(LOSS_THRESH)) begin
            state_d    = HUNT;
            fill_cnt_d = '0;
            win_pos_d  = '0;
            win_err_d  = '0;
          end else if (win_pos == POS_W'(WIN - 1)) begin
            win_pos_d = '0;
            win_err_d = '0;
          end else begin
            win_pos_d = win_pos + POS_W'(1);
            win_err_d = win_err_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Saturating error and checked-bit counters; clear beats a same-cycle count
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      err_count <= '0;
      bit_count <= '0;
    end else begin
      if (err_evt && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
      if (bit_evt && (bit_count != {CNT_W{1'b1}})) begin
        bit_count <= bit_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Directed self-checking bench for prbs_checker: a 32-bit and a 4-bit counter
// instance share one generated PRBS stream with injected errors and gaps.
module tb_prbs_checker;

  localparam logic [15:0] TAPS       = 16'b0110100000000001;
  localparam logic [15:0] WRONG_TAPS = 16'hA011;

  logic        clk;
  logic        rst;
  logic        bit_in;
  logic        bit_vld;
  logic        cnt_clr;
  logic        locked, locked2;
  logic        err_pulse, err_pulse2;
  logic [31:0] err_count, bit_count;
  logic [3:0]  err_count2, bit_count2;

  logic [0:15] g;
  logic [15:0] gtaps;
  int          n_checks;
  int          n_fail;
  int          pulse_cnt;
  int          lock_cycles;
  int          unlock_cycles;

  prbs_checker dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .cnt_clr   (cnt_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  prbs_checker #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .cnt_clr   (cnt_clr),
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_count (err_count2),
    .bit_count (bit_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: advance the reference generator on valid cycles, optionally flip the bit
  task automatic send(input logic flip, input logic vld);
    logic fb;
    if (vld) begin
      fb     = ^(gtaps & g);
      g      = {fb, g[0:14]};
      bit_in = g[0] ^ flip;
    end else begin
      bit_in = ~bit_in;
    end
    bit_vld = vld;
    @(posedge clk);
    #1;
    pulse_cnt += int'(err_pulse);
    if (locked) lock_cycles++;
    else unlock_cycles++;
  endtask

  // Lock must appear on exactly the 48th clean valid bit
  task automatic relock_check(input string tag);
    repeat (47) send(1'b0, 1'b1);
    check({tag, "_before"}, 32'(locked), 32'd0);
    send(1'b0, 1'b1);
    check({tag, "_at48"}, 32'(locked), 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; pulse_cnt = 0; lock_cycles = 0; unlock_cycles = 0;
    rst = 1'b1; bit_vld = 1'b0; bit_in = 1'b0; cnt_clr = 1'b0;
    g = 16'hACE1; gtaps = TAPS;
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_pulse", 32'(err_pulse), 32'd0);
    check("rst_err", err_count, 32'd0);
    check("rst_bits", bit_count, 32'd0);
    rst = 1'b0;

    // Error-free lock
    relock_check("lock1");
    check("lock1_err", err_count, 32'd0);
    check("lock1_bits", bit_count, 32'd0);
    check("lock1_narrow", 32'(locked2), 32'd1);
    pulse_cnt = 0;
    repeat (1000) send(1'b0, 1'b1);
    check("run1000_bits", bit_count, 32'd1000);
    check("run1000_err", err_count, 32'd0);
    check("run1000_pulses", 32'(pulse_cnt), 32'd0);
    check("run1000_bits4_sat", 32'(bit_count2), 32'd15);

    // Single error
    send(1'b1, 1'b1);
    check("single_pulse", 32'(err_pulse), 32'd1);
    check("single_err", err_count, 32'd1);
    send(1'b0, 1'b1);
    check("single_pulse_off", 32'(err_pulse), 32'd0);
    pulse_cnt = 0; unlock_cycles = 0;
    repeat (100) send(1'b0, 1'b1);
    check("single_no_more", 32'(pulse_cnt), 32'd0);
    check("single_err_hold", err_count, 32'd1);
    check("single_stay_locked", 32'(unlock_cycles), 32'd0);
    check("single_bits", bit_count, 32'd1102);

    // Gap stall
    repeat (50) send(1'b0, 1'b0);
    check("gap_bits_hold", bit_count, 32'd1102);
    check("gap_locked", 32'(locked), 32'd1);
    repeat (10) send(1'b0, 1'b1);
    check("gap_resume_bits", bit_count, 32'd1112);
    check("gap_resume_err", err_count, 32'd1);
    check("gap_pulses", 32'(pulse_cnt), 32'd0);

    // Clear, then 20 errors spaced 150 bits apart (never more than 7 per window)
    cnt_clr = 1'b1;
    send(1'b0, 1'b0);
    cnt_clr = 1'b0;
    check("clr_err", err_count, 32'd0);
    check("clr_bits4", 32'(bit_count2), 32'd0);
    pulse_cnt = 0; unlock_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b1);
      repeat (149) send(1'b0, 1'b1);
    end
    check("spread_no_loss", 32'(unlock_cycles), 32'd0);
    check("spread_err", err_count, 32'd20);
    check("spread_pulses", 32'(pulse_cnt), 32'd20);
    check("spread_bits", bit_count, 32'd3000);
    check("spread_err4_sat", 32'(err_count2), 32'd15);
    check("spread_locked4", 32'(locked2), 32'd1);
    cnt_clr = 1'b1;
    send(1'b1, 1'b1);
    cnt_clr = 1'b0;
    check("clr_vs_err", err_count, 32'd0);
    check("clr_vs_err4", 32'(err_count2), 32'd0);
    check("clr_vs_bits", bit_count, 32'd0);
    check("clr_vs_pulse", 32'(err_pulse), 32'd1);

    // Reset mid-LOCKED on an errored bit
    rst = 1'b1;
    send(1'b1, 1'b1);
    rst = 1'b0;
    check("rstL_locked", 32'(locked), 32'd0);
    check("rstL_pulse", 32'(err_pulse), 32'd0);
    check("rstL_err4", 32'(err_count2), 32'd0);
    relock_check("relockL");

    // Loss of lock: 8 errors inside the first window after lock
    repeat (7) send(1'b1, 1'b1);
    check("loss7_locked", 32'(locked), 32'd1);
    send(1'b1, 1'b1);
    check("loss8_locked", 32'(locked), 32'd0);
    check("loss8_err", err_count, 32'd8);
    check("loss8_pulse", 32'(err_pulse), 32'd1);
    relock_check("relock_loss");
    check("relock_err_kept", err_count, 32'd8);
    check("relock_bits", bit_count, 32'd8);

    // Lose again, sit in VERIFY, then reset
    repeat (8) send(1'b1, 1'b1);
    repeat (20) send(1'b0, 1'b1);
    check("verify_unlocked", 32'(locked), 32'd0);
    check("verify_err", err_count, 32'd16);
    rst = 1'b1;
    send(1'b0, 1'b1);
    rst = 1'b0;
    check("rstV_err", err_count, 32'd0);
    check("rstV_bits", bit_count, 32'd0);
    check("rstV_locked", 32'(locked), 32'd0);
    relock_check("relockV");

    // Stream from a different polynomial must never lock
    rst = 1'b1;
    send(1'b0, 1'b0);
    rst = 1'b0;
    gtaps = WRONG_TAPS;
    lock_cycles = 0;
    repeat (300) send(1'b0, 1'b1);
    check("wrong_taps_nolock", 32'(lock_cycles), 32'd0);
    check("wrong_taps_err", err_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
